// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory (progmem strobe protocol) among NUM_PORTS
// requestors. The grant is combinational and uses either round-robin or fixed
// priority. Read data returns one cycle after the grant, and a one-hot owner
// register routes the rvalid back to the port that issued the read.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS-1:0]          req_rstrb,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          req_rvalid,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_rstrb,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int SW    = DATA_W / 8;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] req_s;
    logic [NUM_PORTS-1:0] gnt_oh_s;
    logic [PTR_W-1:0]     gnt_idx_s;
    logic                 gnt_any_s;
    logic [SW-1:0]        gnt_wstrb_s;
    logic                 gnt_wr_s;
    logic                 mem_rstrb_s;
    logic [SW-1:0]        mem_wstrb_s;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [NUM_PORTS-1:0] rd_owner_q, rd_owner_d;

    // A port is requesting when it asserts a read or any byte write enable
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_s[i] = req_rstrb[i] | (|req_wstrb[i*SW +: SW]);
        end
    end

    // Pick the first requesting port, searching upward from the priority base with wrap-around
    always_comb begin
        int base;
        int idx;
        gnt_oh_s  = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        base      = 0;
        idx       = 0;
        if (RR_MODE != 0) begin
            base = int'(ptr_q);
        end else begin
            base = 0;
        end
        if (base >= NUM_PORTS) begin
            base = 0;
        end else begin
            base = base;
        end
        if (rst) begin
            gnt_any_s = 1'b0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = base + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end else begin
                    idx = idx;
                end
                if (!gnt_any_s && req_s[idx]) begin
                    gnt_any_s     = 1'b1;
                    gnt_idx_s     = idx[PTR_W-1:0];
                    gnt_oh_s[idx] = 1'b1;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end
    end

    // Steer the granted port onto the memory bus; a write beats a simultaneous read
    always_comb begin
        gnt_wstrb_s = req_wstrb[gnt_idx_s*SW +: SW];
        gnt_wr_s    = |gnt_wstrb_s;
        mem_addr    = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
        mem_wdata   = req_wdata[gnt_idx_s*DATA_W +: DATA_W];
        if (gnt_any_s) begin
            mem_wstrb_s = gnt_wstrb_s;
            mem_rstrb_s = req_rstrb[gnt_idx_s] & ~gnt_wr_s;
        end else begin
            mem_wstrb_s = '0;
            mem_rstrb_s = 1'b0;
        end
    end

    assign req_ready  = gnt_oh_s;
    assign mem_rstrb  = mem_rstrb_s;
    assign mem_wstrb  = mem_wstrb_s;
    assign req_rdata  = mem_rdata;
    // A read whose data would land in a reset cycle is dropped
    assign req_rvalid = (rd_pend_q && !rst) ? rd_owner_q : '0;

    // Next priority pointer and read-owner tracking
    always_comb begin
        ptr_d      = ptr_q;
        rd_pend_d  = mem_rstrb_s;
        rd_owner_d = '0;
        if ((RR_MODE != 0) && gnt_any_s) begin
            if (gnt_idx_s == PTR_W'(NUM_PORTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
        if (mem_rstrb_s) begin
            rd_owner_d = gnt_oh_s;
        end else begin
            rd_owner_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule
